botsw_gate_seq: RTL and testbench

Break-before-make gate sequencer for the synchronous buck power stage. It converts a single PWM command into non-overlapping top-switch and bottom-switch gate enables, with programmable dead time. It also provides optional diode emulation: the bottom switch is released on inductor current zero-cross, and its body diode carries the remainder. A latched over-current shutdown forces both gates off. Its outputs feed the level shifters that drive the GATE pins of the top-switch and bottom-switch power FET bricks.

---
 rtl/botsw_gate_seq_if.sv | 27 ++
 rtl/botsw_gate_seq.sv | 113 +++++++++++
 tb/tb_botsw_gate_seq.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/botsw_gate_seq_if.sv
// Command/status bundle between the buck controller and the gate sequencer.
// master drives the commands and reads the gate outputs; slave is the sequencer side.
interface botsw_gate_seq_if #(
    parameter int DT_W = 6
);
    logic            EN;
    logic            PWM;
    logic [DT_W-1:0] DT;
    logic            DIODE_EN;
    logic            ZCD;
    logic            OCP;
    logic            GATE_TOP;
    logic            GATE_BOT;
    logic            DIODE_ACT;
    logic            FAULT;
    logic [2:0]      STATE;

    modport master (
        output EN, PWM, DT, DIODE_EN, ZCD, OCP,
        input  GATE_TOP, GATE_BOT, DIODE_ACT, FAULT, STATE
    );

    modport slave (
        input  EN, PWM, DT, DIODE_EN, ZCD, OCP,
        output GATE_TOP, GATE_BOT, DIODE_ACT, FAULT, STATE
    );
endinterface

// File: rtl/botsw_gate_seq.sv
// Break-before-make gate sequencer: PWM to non-overlapping top/bottom gate enables
// with programmable dead time, diode emulation on zero-cross and latched OCP shutdown.
module botsw_gate_seq #(
    parameter int DT_W  = 6,
    parameter int BLANK = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    botsw_gate_seq_if.slave       bus
);
    localparam logic [2:0] S_OFF   = 3'd0;
    localparam logic [2:0] S_DEAD  = 3'd1;
    localparam logic [2:0] S_TOP   = 3'd2;
    localparam logic [2:0] S_BOT   = 3'd3;
    localparam logic [2:0] S_DIODE = 3'd4;
    localparam logic [2:0] S_FLT   = 3'd5;

    localparam logic [3:0] BLANK_L = 4'(BLANK);

    logic [2:0]      state_q, state_d;
    logic [DT_W-1:0] dcnt_q, dcnt_d;
    logic [3:0]      bcnt_q, bcnt_d;
    logic            gate_top_q, gate_top_d;
    logic            gate_bot_q, gate_bot_d;
    logic            diode_act_q, diode_act_d;
    logic            fault_q, fault_d;
    logic [DT_W-1:0] dt_eff;

    // DT is only sampled on DEAD entry, so mid-interval changes cannot stretch it.
    assign dt_eff = (bus.DT == '0) ? DT_W'(1) : bus.DT;

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        bcnt_d  = (bcnt_q != 4'd0) ? bcnt_q - 4'd1 : bcnt_q;

        if (!bus.EN) begin
            state_d = S_OFF;
        end else if (bus.OCP) begin
            state_d = S_FLT;
        end else begin
            case (state_q)
                S_OFF: begin
                    state_d = S_DEAD;
                    dcnt_d  = dt_eff;
                end
                S_DEAD: begin
                    if (dcnt_q <= DT_W'(1)) begin
                        if (bus.PWM) begin
                            state_d = S_TOP;
                        end else begin
                            state_d = S_BOT;
                            bcnt_d  = BLANK_L;
                        end
                    end else begin
                        dcnt_d = dcnt_q - DT_W'(1);
                    end
                end
                S_TOP: begin
                    if (!bus.PWM) begin
                        state_d = S_DEAD;
                        dcnt_d  = dt_eff;
                    end
                end
                S_BOT: begin
                    if (bus.PWM) begin
                        state_d = S_DEAD;
                        dcnt_d  = dt_eff;
                    end else if (bus.DIODE_EN && bus.ZCD && bcnt_q == 4'd0) begin
                        state_d = S_DIODE;
                    end
                end
                // both gates already off here, so top may turn on without dead time
                S_DIODE: begin
                    if (bus.PWM) state_d = S_TOP;
                end
                S_FLT:   state_d = S_FLT;
                default: state_d = S_OFF;
            endcase
        end

        gate_top_d  = (state_d == S_TOP);
        gate_bot_d  = (state_d == S_BOT);
        diode_act_d = (state_d == S_DIODE);
        fault_d     = (state_d == S_FLT);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_OFF;
            dcnt_q      <= '0;
            bcnt_q      <= '0;
            gate_top_q  <= 1'b0;
            gate_bot_q  <= 1'b0;
            diode_act_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            bcnt_q      <= bcnt_d;
            gate_top_q  <= gate_top_d;
            gate_bot_q  <= gate_bot_d;
            diode_act_q <= diode_act_d;
            fault_q     <= fault_d;
        end
    end

    assign bus.GATE_TOP  = gate_top_q;
    assign bus.GATE_BOT  = gate_bot_q;
    assign bus.DIODE_ACT = diode_act_q;
    assign bus.FAULT     = fault_q;
    assign bus.STATE     = state_q;
endmodule

// File: tb/tb_botsw_gate_seq.sv
// Bench for botsw_gate_seq: vector table, hand sequences and a random soak,
// all compared against a timestamp-based reference model.
module tb_botsw_gate_seq;
    localparam int DT_W  = 6;
    localparam int BLANK = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0, pwm = 1'b0, den = 1'b0, zcd = 1'b0, ocp = 1'b0;
    logic [DT_W-1:0] dt = '0;

    botsw_gate_seq_if #(.DT_W(DT_W)) bus ();
    assign bus.EN       = en;
    assign bus.PWM      = pwm;
    assign bus.DT       = dt;
    assign bus.DIODE_EN = den;
    assign bus.ZCD      = zcd;
    assign bus.OCP      = ocp;

    botsw_gate_seq #(.DT_W(DT_W), .BLANK(BLANK)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: modes plus timestamps of when DEAD / BOT_ON began.
    int t = 0;
    int m_st = 0;
    int dead_start = 0, dead_len = 1, bot_start = 0;

    task automatic enter_dead();
        m_st       = 1;
        dead_start = t;
        dead_len   = (dt == 0) ? 1 : int'(dt);
    endtask

    task automatic model_step();
        t++;
        if (rst)       m_st = 0;
        else if (!en)  m_st = 0;
        else if (ocp)  m_st = 5;
        else begin
            case (m_st)
                0: enter_dead();
                1: if (t - dead_start >= dead_len) begin
                       if (pwm) m_st = 2;
                       else begin m_st = 3; bot_start = t; end
                   end
                2: if (!pwm) enter_dead();
                3: if (pwm) enter_dead();
                   else if (den && zcd && (t - bot_start > BLANK)) m_st = 4;
                4: if (pwm) m_st = 2;
                default: ;
            endcase
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, t);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("state",     int'(bus.STATE),     m_st);
        chk("gate_top",  int'(bus.GATE_TOP),  int'(m_st == 2));
        chk("gate_bot",  int'(bus.GATE_BOT),  int'(m_st == 3));
        chk("diode_act", int'(bus.DIODE_ACT), int'(m_st == 4));
        chk("fault",     int'(bus.FAULT),     int'(m_st == 5));
        chk("overlap",   int'(bus.GATE_TOP & bus.GATE_BOT), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; pwm = 1'b0; ocp = 1'b0; zcd = 1'b0; den = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic            rst, en, pwm;
        logic [DT_W-1:0] dt;
        logic            den, zcd, ocp;
        int              st;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic e, input logic p, input int d,
                                input logic de, input logic z, input logic o, input int s);
        vec_t v;
        v.rst = r; v.en = e; v.pwm = p; v.dt = DT_W'(d);
        v.den = de; v.zcd = z; v.ocp = o; v.st = s;
        return v;
    endfunction

    vec_t tbl[21];
    int run, n;

    initial begin
        //          rst en pwm dt den zcd ocp  state
        tbl[0]  = mk(1, 0, 0, 2, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 2, 0, 0, 0, 1);
        tbl[2]  = mk(0, 1, 0, 2, 0, 0, 0, 1);
        tbl[3]  = mk(0, 1, 0, 2, 0, 0, 0, 3);
        tbl[4]  = mk(0, 1, 1, 2, 0, 0, 0, 1);
        tbl[5]  = mk(0, 1, 1, 2, 0, 0, 0, 1);
        tbl[6]  = mk(0, 1, 1, 2, 0, 0, 0, 2);
        tbl[7]  = mk(0, 1, 1, 2, 0, 0, 1, 5);
        tbl[8]  = mk(0, 1, 0, 2, 0, 0, 0, 5);
        tbl[9]  = mk(0, 0, 0, 2, 0, 0, 0, 0);
        tbl[10] = mk(0, 1, 1, 0, 0, 0, 0, 1);
        tbl[11] = mk(0, 1, 1, 0, 0, 0, 0, 2);
        tbl[12] = mk(1, 1, 0, 0, 0, 0, 1, 0);
        tbl[13] = mk(0, 1, 0, 1, 1, 1, 0, 1);
        tbl[14] = mk(0, 1, 0, 1, 1, 1, 0, 3);
        tbl[15] = mk(0, 1, 0, 1, 1, 1, 0, 3);
        tbl[16] = mk(0, 1, 0, 1, 1, 1, 0, 3);
        tbl[17] = mk(0, 1, 0, 1, 1, 1, 0, 3);
        tbl[18] = mk(0, 1, 0, 1, 1, 1, 0, 3);
        tbl[19] = mk(0, 1, 0, 1, 1, 1, 0, 4);
        tbl[20] = mk(0, 1, 1, 1, 1, 1, 0, 2);

        for (int i = 0; i < 21; i++) begin
            rst = tbl[i].rst; en = tbl[i].en; pwm = tbl[i].pwm; dt = tbl[i].dt;
            den = tbl[i].den; zcd = tbl[i].zcd; ocp = tbl[i].ocp;
            tick();
            chk($sformatf("tbl[%0d]", i), int'(bus.STATE), tbl[i].st);
        end

        // basic switching, DT=2, PWM toggling every 10 cycles
        do_reset();
        en = 1'b1; dt = 6'd2; run = 0;
        for (int c = 0; c < 80; c++) begin
            if (c % 10 == 9) pwm = ~pwm;
            tick();
            if (!bus.GATE_TOP && !bus.GATE_BOT) run++;
            else begin
                if (run > 0) chk("dead_len_dt2", run, 2);
                run = 0;
            end
        end

        // DT=63 with DT changed mid-interval
        do_reset();
        en = 1'b1; pwm = 1'b1; dt = 6'd63;
        tick();
        n = 1;
        for (int c = 0; c < 200; c++) begin
            if (c == 3) dt = 6'd5;
            tick();
            if (bus.GATE_TOP) break;
            n++;
        end
        chk("dead_len_dt63", n, 63);

        // ZCD pulses with diode emulation disabled
        do_reset();
        en = 1'b1; pwm = 1'b0; dt = 6'd1; den = 1'b0;
        tick(); tick();
        for (int c = 0; c < 12; c++) begin
            zcd = c[0];
            tick();
            chk("zcd_no_den_bot", int'(bus.GATE_BOT), 1);
            chk("zcd_no_den_diode", int'(bus.DIODE_ACT), 0);
        end
        zcd = 1'b0;

        // OCP during DEAD, hold through PWM toggling, clear and full re-entry
        do_reset();
        en = 1'b1; pwm = 1'b1; dt = 6'd4;
        tick(); tick();
        ocp = 1'b1;
        tick();
        ocp = 1'b0;
        chk("ocp_dead_fault", int'(bus.FAULT), 1);
        for (int c = 0; c < 4; c++) begin
            pwm = ~pwm;
            tick();
            chk("fault_held", int'(bus.FAULT), 1);
        end
        en = 1'b0; pwm = 1'b1;
        tick();
        chk("fault_cleared", int'(bus.FAULT), 0);
        en = 1'b1;
        tick();
        n = 1;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (bus.GATE_TOP || bus.GATE_BOT) break;
            n++;
        end
        chk("recover_dead_len", n, 4);

        // random soak
        do_reset();
        en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(127) == 0);
            en  = ($urandom_range(31) != 0);
            ocp = ($urandom_range(63) == 0);
            zcd = $urandom_range(1);
            if ($urandom_range(7) == 0)  pwm = ~pwm;
            if ($urandom_range(99) == 0) den = ~den;
            if ($urandom_range(15) == 0) dt = DT_W'($urandom_range(5));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
